// File: rtl/apx_add_sched_pkg.sv
// Shared helpers for the approximate-add scheduler: width derivation and the
// round-then-add arithmetic, also used by the bta-family models.
package apx_pkg;

    localparam int FW = 64;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int idw_of(input int nreq);
        return clog2(nreq);
    endfunction

    function automatic int kw_of(input int kmax);
        return clog2(kmax + 1);
    endfunction

    // Evaluated wide; callers truncate to DW, which preserves the modulo result.
    function automatic logic [FW-1:0] apx_rnd_add(input logic [FW-1:0] a,
                                                  input logic [FW-1:0] b,
                                                  input logic [5:0]    k);
        logic [FW-1:0] ar, br;
        if (k == 6'd0) return a + b;
        ar = (a >> k) + FW'(a[k - 6'd1]);
        br = (b >> k) + FW'(b[k - 6'd1]);
        return (ar + br) << k;
    endfunction

endpackage

// File: rtl/apx_add_sched_if.sv
// Request/result handshake bundle between accelerator lanes and the shared adder.
interface apx_add_sched_if #(
    parameter int DW   = 16,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    i_req_vld;
    logic [NREQ*DW-1:0] i_req_a;
    logic [NREQ*DW-1:0] i_req_b;
    logic [NREQ-1:0]    o_req_rdy;
    logic               o_res_vld;
    logic [DW-1:0]      o_res;
    logic [IDW-1:0]     o_res_id;
    logic               i_res_rdy;

    modport master (output i_req_vld, i_req_a, i_req_b, i_res_rdy,
                    input  o_req_rdy, o_res_vld, o_res, o_res_id);
    modport slave  (input  i_req_vld, i_req_a, i_req_b, i_res_rdy,
                    output o_req_rdy, o_res_vld, o_res, o_res_id);
endinterface

// File: rtl/apx_add_sched_rr_arb.sv
// Round-robin arbiter: first valid requester at or after the pointer, wrapping.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_vld,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_id
);
    logic [IDW:0] idx;

    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        idx      = '0;
        // Walk from the farthest offset back to the pointer so the nearest valid wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = {1'b0, i_ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
            if (i_en && i_vld[idx[IDW-1:0]]) begin
                o_gnt                 = '0;
                o_gnt[idx[IDW-1:0]]   = 1'b1;
                o_gnt_id              = idx[IDW-1:0];
            end
        end
    end
endmodule

// File: rtl/apx_add_sched.sv
// Shares one round-then-add approximate adder among NREQ requesters through a
// 2-stage pipeline with per-requester approximation level and result backpressure.
module apx_add_sched
    import apx_pkg::*;
#(
    parameter int DW        = 16,
    parameter int NREQ      = 4,
    parameter int DW_AC_MAX = 8,
    parameter int IDW       = idw_of(NREQ),
    parameter int KW        = kw_of(DW_AC_MAX)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    apx_add_sched_if.slave bus,
    input  logic           i_cfg_we,
    input  logic [IDW-1:0] i_cfg_id,
    input  logic [KW-1:0]  i_cfg_k
);
    logic [NREQ-1:0][KW-1:0] k_q;
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [2:1]              vld_pipe_q, vld_pipe_d;
    logic [DW-1:0]           s1_a_q, s1_b_q, s2_res_q, s1_res;
    logic [KW-1:0]           s1_k_q, cfg_k_sat;
    logic [IDW-1:0]          s1_id_q, s2_id_q;
    logic [NREQ-1:0][DW-1:0] req_a, req_b;
    logic [NREQ-1:0]         gnt;
    logic [IDW-1:0]          gnt_id;
    logic                    s2_hold, s1_free, acc;

    assign req_a     = bus.i_req_a;
    assign req_b     = bus.i_req_b;
    assign s2_hold   = vld_pipe_q[2] & ~bus.i_res_rdy;
    assign s1_free   = ~vld_pipe_q[1] | ~s2_hold;
    assign acc       = |gnt;
    assign cfg_k_sat = (i_cfg_k > KW'(DW_AC_MAX)) ? KW'(DW_AC_MAX) : i_cfg_k;
    assign s1_res    = DW'(apx_rnd_add(FW'(s1_a_q), FW'(s1_b_q), 6'(s1_k_q)));

    // Grants are suppressed in reset so nothing appears accepted on a dropped cycle.
    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_vld    (bus.i_req_vld),
        .i_ptr    (ptr_q),
        .i_en     (s1_free & ~i_rst),
        .o_gnt    (gnt),
        .o_gnt_id (gnt_id)
    );

    always_comb begin
        ptr_d         = ptr_q;
        vld_pipe_d    = vld_pipe_q;
        if (acc) ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        if (s1_free) vld_pipe_d[1] = acc;
        if (!s2_hold) vld_pipe_d[2] = vld_pipe_q[1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            k_q        <= '0;
            ptr_q      <= '0;
            vld_pipe_q <= '0;
            s2_res_q   <= '0;
            s2_id_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            vld_pipe_q <= vld_pipe_d;
            if (i_cfg_we && (int'(i_cfg_id) < NREQ)) k_q[i_cfg_id] <= cfg_k_sat;
            if (!s2_hold && vld_pipe_q[1]) begin
                s2_res_q <= s1_res;
                s2_id_q  <= s1_id_q;
            end
        end
    end

    // k is read before any same-cycle config write lands.
    always_ff @(posedge i_clk) begin
        if (acc) begin
            s1_a_q  <= req_a[gnt_id];
            s1_b_q  <= req_b[gnt_id];
            s1_k_q  <= k_q[gnt_id];
            s1_id_q <= gnt_id;
        end
    end

    assign bus.o_req_rdy = gnt;
    assign bus.o_res_vld = vld_pipe_q[2];
    assign bus.o_res     = s2_res_q;
    assign bus.o_res_id  = s2_id_q;
endmodule
